reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
// - 32-entry integer register file of the RISC-V core; sits directly upstream of the ALU.
// - Two combinational read ports drive ALUop1/ALUop2 (RD2 via imm mux); one synchronous write port takes writeback.
// - x0 hardwired to zero; x10 (a0) exported for lab observation/testbench checking.
// PARAMETERS
// - ADDR_WIDTH  5   register index width (2**ADDR_WIDTH entries)
// - DATA_WIDTH  32  register / datapath width, equal to ALU DATA_WIDTH
// PORTS
// - clk   input   1           core clock; all state updates on rising edge
// - rst   input   1           synchronous, active-high reset
// - AD1   input   ADDR_WIDTH  read port 1 index (rs1)
// - AD2   input   ADDR_WIDTH  read port 2 index (rs2)
// - AD3   input   ADDR_WIDTH  write index (rd)
// - WE3   input   1           write enable
// - WD3   input   DATA_WIDTH  write data (writeback result)
// - RD1   output  DATA_WIDTH  read data 1 -> ALUop1
// - RD2   output  DATA_WIDTH  read data 2 -> ALUop2 path
// - a0    output  DATA_WIDTH  stored value of x10, no bypass
// BEHAVIOUR
// - One clock (clk); reset is synchronous, active-high (rst); no asynchronous paths into state.
// - Storage: 2**ADDR_WIDTH x DATA_WIDTH flops; entry 0 never written, always reads 0.
// - Reset: rst high at rising edge clears every entry to 0; rst wins over a coincident WE3 write.
// - Output reset values: after first rst edge RD1 = RD2 = a0 = 0 for every address.
// - Reset mid-operation: any pending write in that cycle is dropped; no partial state survives.
// - Write: at rising edge with rst=0, WE3=1, AD3!=0 -> mem[AD3] <= WD3; latency 1 cycle.
// - WE3=1 with AD3=0: silently ignored, no state change.
// - Read: RD1 = (AD1==0) ? 0 : mem[AD1]; RD2 likewise with AD2; purely combinational, 0-cycle latency.
// - Both ports may address the same register simultaneously; both return identical data.
// - a0 = mem[10] combinationally; shows the written value only after the write edge.
// - No arithmetic; widths exact, no truncation or extension inside the block.
// CONFIGURATION
// - Macro REG_FILE_WRITE_BYPASS_EN:
//   - defined: write-first forwarding; if WE3=1, AD3!=0, AD3==ADx, and rst=0, RDx = WD3 in the same
//     cycle (before the edge); x0 reads still return 0; a0 never bypassed.
//   - undefined: read-old; RDx returns stored value, new data visible the cycle after the write edge.
//   - Default build (single-cycle core): undefined.
// STRUCTURE
// - Package reg_file_pkg: REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0, REG_A0=5'd10,
//   typedef logic [REG_ADDR_W-1:0] reg_addr_t, typedef logic [REG_DATA_W-1:0] reg_data_t.
// - One sub-module reg_file_read_port: index + storage view + optional bypass inputs -> read data
//   (zero-check and bypass mux); instantiated twice (RD1, RD2).
// - Top holds the storage array, reset/write always_ff block and a0 tap.
// TESTING
// - Reset: write x5=0xDEADBEEF, assert rst 1 cycle -> RD1(AD1=5)=0, a0=0, all 32 entries read 0.
// - Write/read: WE3=1 AD3=7 WD3=0x12345678, next cycle AD1=7 AD2=7 -> RD1=RD2=0x12345678.
// - x0: WE3=1 AD3=0 WD3=0xFFFFFFFF -> next cycle AD1=0 gives RD1=0; no other entry changed.
// - rst+write collision: rst=1 WE3=1 AD3=10 WD3=0x55 same edge -> a0=0 after edge.
// - a0 tap: write x10=0x000000FF -> a0=0xFF after edge, a0 unchanged while WE3=0 for 5 cycles.
// - Bypass: WE3=1 AD3=3 WD3=0xA5A5A5A5, AD1=3 in same cycle, old x3=0 -> RD1=0xA5A5A5A5 with
//   REG_FILE_WRITE_BYPASS_EN, RD1=0 without; both builds RD1=0xA5A5A5A5 next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths, well-known register indices and payload types for the integer register file.
package reg_file_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_A0   = 5'd10;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: x0 forced to zero, optional write-first forwarding.
// Forwarding is compiled in only when REG_FILE_WRITE_BYPASS_EN is defined.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH = REG_DATA_W,
  localparam int unsigned DEPTH     = 2**ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] mem [DEPTH],
  input  logic                  byp_we,
  input  logic [ADDR_WIDTH-1:0] byp_addr,
  input  logic [DATA_WIDTH-1:0] byp_data,
  output logic [DATA_WIDTH-1:0] data
);

`ifdef REG_FILE_WRITE_BYPASS_EN
  // A matching in-flight write overrides the stored value; x0 stays zero regardless.
  always_comb begin
    data = '0;
    if (addr != '0) begin
      if (byp_we && (byp_addr == addr)) begin
        data = byp_data;
      end else begin
        data = mem[addr];
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_we, byp_addr, byp_data};

  always_comb begin
    data = '0;
    if (addr != '0) begin
      data = mem[addr];
    end
  end
`endif

endmodule

// File: rtl/reg_file.sv
// 32 x 32 RISC-V integer register file: two combinational reads, one synchronous write, a0 tap.
// Optional write-first forwarding on the read ports via REG_FILE_WRITE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH = REG_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  byp_we;

  // Reset wins over a coincident write; writes to x0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (WE3 && (AD3 != '0)) begin
      regs[AD3] <= WD3;
    end
  end

  // Forwarding must not expose data from a write that reset is about to discard.
  assign byp_we = WE3 & ~rst;

  reg_file_read_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd1 (
    .addr     (AD1),
    .mem      (regs),
    .byp_we   (byp_we),
    .byp_addr (AD3),
    .byp_data (WD3),
    .data     (RD1)
  );

  reg_file_read_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd2 (
    .addr     (AD2),
    .mem      (regs),
    .byp_we   (byp_we),
    .byp_addr (AD3),
    .byp_data (WD3),
    .data     (RD2)
  );

  // a0 always shows stored state, never forwarded data.
  assign a0 = regs[ADDR_WIDTH'(REG_A0)];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_WRITE_BYPASS_EN if defined.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2, a0;

  int checks;
  int failures;

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .AD1 (AD1),
    .AD2 (AD2),
    .AD3 (AD3),
    .WE3 (WE3),
    .WD3 (WD3),
    .RD1 (RD1),
    .RD2 (RD2),
    .a0  (a0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_byp;
    checks   = 0;
    failures = 0;
    clk = 1'b0;
    rst = 1'b1;
    AD1 = 5'd5; AD2 = 5'd0; AD3 = 5'd0; WE3 = 1'b0; WD3 = 32'h0;

    // Initial reset
    tick();
    rst = 1'b0;
    #1;
    check("reset_rd1_x5", RD1, 32'h0);
    check("reset_a0", a0, 32'h0);

    // Write x5, then reset clears it and every other entry
    WE3 = 1'b1; AD3 = 5'd5; WD3 = 32'hDEADBEEF;
    tick();
    WE3 = 1'b0;
    #1;
    check("x5_written", RD1, 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("x5_after_rst", RD1, 32'h0);
    check("a0_after_rst", a0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      AD1 = 5'(i);
      AD2 = 5'(31 - i);
      #1;
      check($sformatf("rst_all_rd1_x%0d", i), RD1, 32'h0);
      check($sformatf("rst_all_rd2_x%0d", 31 - i), RD2, 32'h0);
    end

    // Write x7, read on both ports next cycle
    WE3 = 1'b1; AD3 = 5'd7; WD3 = 32'h12345678;
    tick();
    WE3 = 1'b0;
    AD1 = 5'd7; AD2 = 5'd7;
    #1;
    check("x7_rd1", RD1, 32'h12345678);
    check("x7_rd2", RD2, 32'h12345678);

    // Write to x0 is ignored
    WE3 = 1'b1; AD3 = 5'd0; WD3 = 32'hFFFFFFFF;
    tick();
    WE3 = 1'b0;
    AD1 = 5'd0; AD2 = 5'd7;
    #1;
    check("x0_rd1", RD1, 32'h0);
    check("x0_keep_x7", RD2, 32'h12345678);
    AD2 = 5'd5;
    #1;
    check("x0_keep_x5", RD2, 32'h0);
    check("x0_keep_a0", a0, 32'h0);

    // a0 tap: no change before the edge, holds while WE3=0
    WE3 = 1'b1; AD3 = 5'd10; WD3 = 32'h000000FF;
    #1;
    check("a0_pre_edge", a0, 32'h0);
    tick();
    WE3 = 1'b0;
    #1;
    check("a0_post_edge", a0, 32'h000000FF);
    for (int c = 0; c < 5; c++) begin
      AD3 = 5'd10; WD3 = 32'hBAD0_0000 + 32'(c);
      tick();
      check($sformatf("a0_hold_%0d", c), a0, 32'h000000FF);
    end
    AD1 = 5'd10;
    #1;
    check("x10_rd1", RD1, 32'h000000FF);

    // Reset and write on the same edge: reset wins
    rst = 1'b1; WE3 = 1'b1; AD3 = 5'd10; WD3 = 32'h55;
    tick();
    rst = 1'b0; WE3 = 1'b0;
    AD1 = 5'd7;
    #1;
    check("rst_coll_a0", a0, 32'h0);
    check("rst_coll_x7", RD1, 32'h0);

    // Same-cycle read of a register being written
`ifdef REG_FILE_WRITE_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h0;
`endif
    WE3 = 1'b1; AD3 = 5'd3; WD3 = 32'hA5A5A5A5; AD1 = 5'd3; AD2 = 5'd0;
    #1;
    check("byp_same_cycle", RD1, exp_byp);
    check("byp_x0_rd2", RD2, 32'h0);
    tick();
    WE3 = 1'b0;
    #1;
    check("byp_next_cycle", RD1, 32'hA5A5A5A5);

    // Forwarding of a0 never happens
    WE3 = 1'b1; AD3 = 5'd10; WD3 = 32'h0000_1234;
    #1;
    check("a0_no_byp", a0, 32'h0);
    tick();
    WE3 = 1'b0;
    #1;
    check("a0_after_write", a0, 32'h0000_1234);

    // A write coinciding with reset is never forwarded
    rst = 1'b1; WE3 = 1'b1; AD3 = 5'd3; WD3 = 32'h0000_0001; AD1 = 5'd3;
    #1;
    check("rst_no_byp", RD1, 32'hA5A5A5A5);
    tick();
    rst = 1'b0; WE3 = 1'b0;
    #1;
    check("rst_no_byp_after", RD1, 32'h0);
    check("rst_a0_cleared", a0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
